// File: rtl/param_stack.sv
// LIFO stack with registered read port, sticky overflow/underflow flags and
// a push+pop exchange/bypass path. Storage is not reset; only control state is.
module param_stack #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             top,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [CNT_W-1:0] cnt_m1;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  logic [WIDTH-1:0] rd_data;
  logic             wr_en;
  logic             is_empty;
  logic             is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_W'(DEPTH));
  assign cnt_m1   = count_q - CNT_W'(1);
  // Index is only consumed when the stack is non-empty, so the wrap at zero is harmless.
  assign top_idx  = AW'(cnt_m1);
  assign rd_data  = mem[top_idx];

  // Decode the single operation for this cycle: clear > push/pop > top.
  always_comb begin
    count_d = count_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    wr_idx  = AW'(count_q);
    if (clear) begin
      count_d = '0;
      dout_d  = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (push && pop) begin
      valid_d = 1'b1;
      if (is_empty) begin
        // Bypass: nothing stored, data passes straight through.
        dout_d = din;
      end else begin
        // Exchange: old top goes out, new word replaces it in place.
        dout_d = rd_data;
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end
    end else if (push) begin
      if (is_full) begin
        ovf_d = 1'b1;
      end else begin
        wr_en   = 1'b1;
        count_d = count_q + CNT_W'(1);
      end
    end else if (pop) begin
      if (is_empty) begin
        unf_d = 1'b1;
      end else begin
        dout_d  = rd_data;
        count_d = cnt_m1;
        valid_d = 1'b1;
      end
    end else if (top) begin
      if (!is_empty) begin
        dout_d  = rd_data;
        valid_d = 1'b1;
      end
    end
  end

  // Control and read-data registers; asynchronous reset clears them immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage array, unreset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (wr_en && rst) begin
      mem[wr_idx] <= din;
    end
  end

  assign dout      = dout_q;
  assign valid     = valid_q;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack: a 4x4 instance for the main scenarios and an
// 8-bit, depth-5 instance for the non-power-of-two depth case.
module tb_param_stack;

  logic clk;
  logic rst;

  // Instance A: WIDTH=4, DEPTH=4
  logic       a_push, a_pop, a_top, a_clear;
  logic [3:0] a_din, a_dout;
  logic       a_valid, a_empty, a_full, a_ovf, a_unf;
  logic [2:0] a_count;

  // Instance B: WIDTH=8, DEPTH=5
  logic       b_push, b_pop, b_top, b_clear;
  logic [7:0] b_din, b_dout;
  logic       b_valid, b_empty, b_full, b_ovf, b_unf;
  logic [2:0] b_count;

  int n_checks;
  int n_fail;

  param_stack #(.WIDTH(4), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .push(a_push), .pop(a_pop), .top(a_top), .clear(a_clear),
    .din(a_din), .dout(a_dout), .valid(a_valid), .count(a_count), .empty(a_empty),
    .full(a_full), .overflow(a_ovf), .underflow(a_unf)
  );

  param_stack #(.WIDTH(8), .DEPTH(5)) dut_b (
    .clk(clk), .rst(rst), .push(b_push), .pop(b_pop), .top(b_top), .clear(b_clear),
    .din(b_din), .dout(b_dout), .valid(b_valid), .count(b_count), .empty(b_empty),
    .full(b_full), .overflow(b_ovf), .underflow(b_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clocked operation on instance A; outputs are sampled 1 time unit after the edge.
  task automatic a_op(input logic p, input logic po, input logic t, input logic c,
                      input logic [3:0] d);
    a_push = p; a_pop = po; a_top = t; a_clear = c; a_din = d;
    tick();
    a_push = 1'b0; a_pop = 1'b0; a_top = 1'b0; a_clear = 1'b0; a_din = '0;
  endtask

  task automatic b_op(input logic p, input logic po, input logic [7:0] d);
    b_push = p; b_pop = po; b_din = d;
    tick();
    b_push = 1'b0; b_pop = 1'b0; b_din = '0;
  endtask

  task automatic test_reset();
    n_checks++; if (a_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", a_count); end
    n_checks++; if (a_dout !== 4'd0) begin n_fail++; $display("FAIL reset_dout got %0d want 0", a_dout); end
    n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", a_valid); end
    n_checks++; if (a_empty !== 1'b1 || a_full !== 1'b0) begin n_fail++; $display("FAIL reset_flags empty=%0b full=%0b want 1/0", a_empty, a_full); end
    n_checks++; if (a_ovf !== 1'b0 || a_unf !== 1'b0) begin n_fail++; $display("FAIL reset_err ovf=%0b unf=%0b want 0/0", a_ovf, a_unf); end
    rst = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 4; i++) begin
      a_op(1'b1, 1'b0, 1'b0, 1'b0, 4'(i));
      n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL push_valid[%0d] got %0b want 0", i, a_valid); end
    end
    n_checks++; if (a_count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d want 4", a_count); end
    n_checks++; if (a_full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %0b want 1", a_full); end
    for (int i = 0; i < 4; i++) begin
      a_op(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      n_checks++; if (a_dout !== 4'(4 - i) || a_valid !== 1'b1) begin n_fail++; $display("FAIL drain_pop[%0d] dout=%0d valid=%0b want %0d/1", i, a_dout, a_valid, 4 - i); end
    end
    n_checks++; if (a_empty !== 1'b1 || a_count !== 3'd0) begin n_fail++; $display("FAIL drain_empty empty=%0b count=%0d want 1/0", a_empty, a_count); end
    tick();
    n_checks++; if (a_valid !== 1'b0 || a_dout !== 4'd1) begin n_fail++; $display("FAIL idle_hold valid=%0b dout=%0d want 0/1", a_valid, a_dout); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) a_op(1'b1, 1'b0, 1'b0, 1'b0, 4'(i));
    a_op(1'b1, 1'b0, 1'b0, 1'b0, 4'd9);
    n_checks++; if (a_ovf !== 1'b1 || a_count !== 3'd4) begin n_fail++; $display("FAIL ovf_set ovf=%0b count=%0d want 1/4", a_ovf, a_count); end
    a_op(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    n_checks++; if (a_dout !== 4'd4 || a_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_pop dout=%0d ovf=%0b want 4/1", a_dout, a_ovf); end
    for (int i = 0; i < 3; i++) a_op(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    n_checks++; if (a_dout !== 4'd1 || a_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky dout=%0d ovf=%0b want 1/1", a_dout, a_ovf); end
    a_op(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    n_checks++; if (a_ovf !== 1'b0 || a_dout !== 4'd0) begin n_fail++; $display("FAIL ovf_clear ovf=%0b dout=%0d want 0/0", a_ovf, a_dout); end
  endtask

  task automatic test_underflow_top_clear();
    a_op(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    n_checks++; if (a_unf !== 1'b1 || a_valid !== 1'b0 || a_count !== 3'd0) begin n_fail++; $display("FAIL unf_set unf=%0b valid=%0b count=%0d want 1/0/0", a_unf, a_valid, a_count); end
    a_op(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    n_checks++; if (a_valid !== 1'b0 || a_dout !== 4'd0) begin n_fail++; $display("FAIL top_empty valid=%0b dout=%0d want 0/0", a_valid, a_dout); end
    a_op(1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
    a_op(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    n_checks++; if (a_dout !== 4'd5 || a_valid !== 1'b1 || a_count !== 3'd1) begin n_fail++; $display("FAIL top_read dout=%0d valid=%0b count=%0d want 5/1/1", a_dout, a_valid, a_count); end
    // top is ignored when push is also asserted
    a_op(1'b1, 1'b0, 1'b1, 1'b0, 4'd3);
    n_checks++; if (a_valid !== 1'b0 || a_count !== 3'd2) begin n_fail++; $display("FAIL top_ignored valid=%0b count=%0d want 0/2", a_valid, a_count); end
    // clear wins over a simultaneous push
    a_op(1'b1, 1'b0, 1'b0, 1'b1, 4'd6);
    n_checks++; if (a_unf !== 1'b0 || a_count !== 3'd0 || a_dout !== 4'd0) begin n_fail++; $display("FAIL clear unf=%0b count=%0d dout=%0d want 0/0/0", a_unf, a_count, a_dout); end
  endtask

  task automatic test_exchange();
    a_op(1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
    a_op(1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
    a_op(1'b1, 1'b1, 1'b0, 1'b0, 4'd7);
    n_checks++; if (a_dout !== 4'd2 || a_valid !== 1'b1 || a_count !== 3'd2) begin n_fail++; $display("FAIL xchg dout=%0d valid=%0b count=%0d want 2/1/2", a_dout, a_valid, a_count); end
    a_op(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    n_checks++; if (a_dout !== 4'd7) begin n_fail++; $display("FAIL xchg_pop got %0d want 7", a_dout); end
    a_op(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    n_checks++; if (a_dout !== 4'd1) begin n_fail++; $display("FAIL xchg_pop2 got %0d want 1", a_dout); end
    a_op(1'b1, 1'b1, 1'b0, 1'b0, 4'd6);
    n_checks++; if (a_dout !== 4'd6 || a_valid !== 1'b1 || a_count !== 3'd0) begin n_fail++; $display("FAIL bypass dout=%0d valid=%0b count=%0d want 6/1/0", a_dout, a_valid, a_count); end
    n_checks++; if (a_ovf !== 1'b0 || a_unf !== 1'b0) begin n_fail++; $display("FAIL bypass_flags ovf=%0b unf=%0b want 0/0", a_ovf, a_unf); end
    for (int i = 1; i <= 4; i++) a_op(1'b1, 1'b0, 1'b0, 1'b0, 4'(i + 10));
    a_op(1'b1, 1'b1, 1'b0, 1'b0, 4'd3);
    n_checks++; if (a_dout !== 4'd14 || a_count !== 3'd4 || a_ovf !== 1'b0) begin n_fail++; $display("FAIL xchg_full dout=%0d count=%0d ovf=%0b want 14/4/0", a_dout, a_count, a_ovf); end
    a_op(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    n_checks++; if (a_dout !== 4'd3) begin n_fail++; $display("FAIL xchg_full_pop got %0d want 3", a_dout); end
    a_op(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 3; i++) a_op(1'b1, 1'b0, 1'b0, 1'b0, 4'(i));
    a_op(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    n_checks++; if (a_dout !== 4'd3 || a_count !== 3'd3) begin n_fail++; $display("FAIL pre_rst dout=%0d count=%0d want 3/3", a_dout, a_count); end
    a_pop = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (a_count !== 3'd0 || a_valid !== 1'b0 || a_dout !== 4'd0) begin n_fail++; $display("FAIL async_rst count=%0d valid=%0b dout=%0d want 0/0/0", a_count, a_valid, a_dout); end
    tick();
    a_pop = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    a_op(1'b1, 1'b0, 1'b0, 1'b0, 4'd8);
    n_checks++; if (a_count !== 3'd1) begin n_fail++; $display("FAIL post_rst_push count=%0d want 1", a_count); end
    a_op(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    n_checks++; if (a_dout !== 4'd8 || a_valid !== 1'b1) begin n_fail++; $display("FAIL post_rst_pop dout=%0d valid=%0b want 8/1", a_dout, a_valid); end
  endtask

  task automatic test_depth5();
    logic [7:0] vals [5];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44; vals[4] = 8'h55;
    for (int i = 0; i < 5; i++) b_op(1'b1, 1'b0, vals[i]);
    n_checks++; if (b_full !== 1'b1 || b_count !== 3'd5) begin n_fail++; $display("FAIL d5_full full=%0b count=%0d want 1/5", b_full, b_count); end
    b_op(1'b1, 1'b0, 8'hEE);
    n_checks++; if (b_ovf !== 1'b1 || b_count !== 3'd5) begin n_fail++; $display("FAIL d5_ovf ovf=%0b count=%0d want 1/5", b_ovf, b_count); end
    for (int i = 4; i >= 0; i--) begin
      b_op(1'b0, 1'b1, 8'h00);
      n_checks++; if (b_dout !== vals[i] || b_valid !== 1'b1) begin n_fail++; $display("FAIL d5_pop[%0d] dout=%0h valid=%0b want %0h/1", i, b_dout, b_valid, vals[i]); end
    end
    n_checks++; if (b_empty !== 1'b1 || b_count !== 3'd0) begin n_fail++; $display("FAIL d5_empty empty=%0b count=%0d want 1/0", b_empty, b_count); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    a_push = 1'b0; a_pop = 1'b0; a_top = 1'b0; a_clear = 1'b0; a_din = '0;
    b_push = 1'b0; b_pop = 1'b0; b_top = 1'b0; b_clear = 1'b0; b_din = '0;
    tick();
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow_top_clear();
    test_exchange();
    test_async_reset();
    test_depth5();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_stack.md
PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data word width in bits (legal range 1..32).
REQ-002 SHALL have parameter DEPTH, default 32, number of storage entries (legal range 2..1024, not required to be a power of two).
REQ-003 SHALL derive CNT_W = ceil(log2(DEPTH+1)) as a local constant; it is not overridable.
REQ-004 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port: rst  input  1  asynchronous, active-low reset; asserting (0) resets immediately, deassertion is synchronous to clk.
REQ-006 SHALL have port: push  input  1  write din onto the stack this cycle.
REQ-007 SHALL have port: pop  input  1  remove the top entry and present it on dout.
REQ-008 SHALL have port: top  input  1  present the top entry on dout without removal.
REQ-009 SHALL have port: clear  input  1  synchronous flush of stack and error flags.
REQ-010 SHALL have port: din  input  WIDTH  data to push.
REQ-011 SHALL have port: dout  output  WIDTH  registered read data.
REQ-012 SHALL have port: valid  output  1  one-cycle pulse, high when dout was updated by the previous edge.
REQ-013 SHALL have port: count  output  CNT_W  current number of stored entries.
REQ-014 SHALL have port: empty  output  1  count == 0, combinational from count.
REQ-015 SHALL have port: full  output  1  count == DEPTH, combinational from count.
REQ-016 SHALL have port: overflow  output  1  sticky, set by a push rejected while full.
REQ-017 SHALL have port: underflow  output  1  sticky, set by a pop while empty.

Function
REQ-018 SHALL sample all controls on the rising clk edge; one operation per cycle, priority clear > push/pop > top.
REQ-019 SHALL, on clear: count=0, dout=0, valid=0, overflow=0, underflow=0; push/pop/top in the same cycle are ignored.
REQ-020 SHALL, on push only and not full: write din to entry[count], count+1, dout unchanged, valid=0.
REQ-021 SHALL, on push only while full: leave storage and count unchanged, set overflow; rejected data is discarded.
REQ-022 SHALL, on pop only and not empty: dout=entry[count-1], count-1, valid=1 next cycle.
REQ-023 SHALL, on pop only while empty: leave dout and count unchanged, valid=0, set underflow; count never wraps below 0.
REQ-024 SHALL, on push and pop together with count>0 (including full): exchange -- dout=old entry[count-1], entry[count-1]=din, count unchanged, valid=1, no flag set.
REQ-025 SHALL, on push and pop together while empty: bypass -- dout=din, count stays 0, valid=1, no flag set.
REQ-026 SHALL, on top alone with count>0: dout=entry[count-1], count unchanged, valid=1; top alone while empty: no change, valid=0, no flag.
REQ-027 SHALL ignore top whenever push or pop is asserted in the same cycle.
REQ-028 SHALL have read latency of exactly one clock: dout/valid reflect the operation sampled at the preceding edge.
REQ-029 SHALL keep dout stable between read operations; valid SHALL be low in every cycle not following a successful read, exchange or bypass.
REQ-030 SHALL keep overflow and underflow set until clear or reset; new errors SHALL not clear them.
REQ-031 SHALL never modify storage contents except via successful push or exchange; storage contents SHALL not be reset.

Reset
REQ-032 SHALL, while rst=0, force count=0, dout=0, valid=0, overflow=0, underflow=0, independent of clk.
REQ-033 SHALL abort any operation in the cycle reset asserts; after release, the stack is empty and the first push writes entry 0.

Verification
REQ-034 SHALL test: WIDTH=4, DEPTH=4; push 1,2,3,4 -> full=1, count=4; pop x4 -> dout 4,3,2,1 each with valid=1 one cycle later, empty=1.
REQ-035 SHALL test: full stack, push 9 -> overflow=1, count=4; next pop -> dout=4 (9 not stored); overflow still 1.
REQ-036 SHALL test: empty stack, pop -> underflow=1, valid=0, count=0; push 5 then top -> dout=5, count=1; clear -> underflow=0, count=0, dout=0.
REQ-037 SHALL test: stack {1,2}, push 7 and pop together -> dout=2, valid=1, count=2; pop -> dout=7; empty stack push 6 and pop together -> dout=6, count=0.
REQ-038 SHALL test: rst driven low mid-cycle during a pop with count=3 -> count=0, valid=0, dout=0 immediately without a clk edge; after release push 8, pop -> dout=8.
REQ-039 SHALL test: DEPTH=5, WIDTH=8; fill to 5 -> full=1, count=5 (no power-of-two wrap); pop all -> values in exact reverse order.
